// File: rtl/pll_phase_stepper.sv
// Dynamic phase stepper for a PLL with PSSEL/PSDIR/PSPULSE phase-shift control.
// Each accepted request names a channel and an absolute target phase. The
// block takes the shortest path around the phase circle, emits one pulse per
// step, and then waits for the PLL to report lock again. The phase it believes
// each channel holds is shown on cur_phase.
module pll_phase_stepper #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned STEP_W    = 7,
  parameter int unsigned PERIOD    = 64,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned LOCK_TO   = 4096
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_ch,
  input  logic [STEP_W-1:0]       req_phase,
  input  logic                    pll_lock,
  output logic [2:0]              pssel,
  output logic                    psdir,
  output logic                    pspulse,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [NCH*STEP_W-1:0]   cur_phase
);

  localparam int unsigned CYC_MAX0 = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CYC_MAX  = (CYC_MAX0 > 2) ? CYC_MAX0 : 2;
  localparam int unsigned CYC_W    = $clog2(CYC_MAX + 1);
  localparam int unsigned WAIT_W   = (LOCK_TO > 1) ? $clog2(LOCK_TO + 1) : 1;

  // One extra bit so the modular difference never overflows.
  localparam logic [STEP_W:0]   PERIOD_X = (STEP_W + 1)'(PERIOD);
  localparam logic [STEP_W:0]   HALF_X   = PERIOD_X >> 1;
  localparam logic [STEP_W-1:0] LAST_PH  = STEP_W'(PERIOD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulseHi,
    StPulseLo,
    StWaitLock
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          ch_q;
  logic                dir_q;
  logic [STEP_W:0]     steps_q;
  logic [CYC_W-1:0]    cyc_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                done_q, err_q;
  logic [STEP_W-1:0]   cur_q [NCH];

  logic                accept, req_bad, req_go;
  logic [STEP_W-1:0]   cur_sel, cur_act, cur_next;
  logic [STEP_W:0]     diff_raw, delta, req_steps;
  logic                req_dir;
  logic                setup_end, pulse_end, gap_end, lock_timeout;
  logic                done_d, err_d;

  // Request decode: legality, modular distance and shortest direction.
  always_comb begin
    cur_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (req_ch == 3'(i)) cur_sel = cur_q[i];
    end
    accept    = req_valid && (state_q == StIdle);
    req_bad   = (32'(req_ch) >= NCH) || (32'(req_phase) >= PERIOD);
    diff_raw  = {1'b0, req_phase} + PERIOD_X - {1'b0, cur_sel};
    delta     = (diff_raw >= PERIOD_X) ? diff_raw - PERIOD_X : diff_raw;
    // A tie at half a period goes the increment way.
    req_dir   = (delta > HALF_X);
    req_steps = req_dir ? (PERIOD_X - delta) : delta;
    req_go    = accept && !req_bad && (delta != '0);
  end

  // Phase of the channel being stepped and its value after one more step.
  always_comb begin
    cur_act = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_q == 3'(i)) cur_act = cur_q[i];
    end
    if (dir_q) cur_next = (cur_act == '0) ? LAST_PH : cur_act - STEP_W'(1);
    else       cur_next = (cur_act == LAST_PH) ? '0 : cur_act + STEP_W'(1);
  end

  // Phase-end conditions shared by the FSM and the datapath.
  always_comb begin
    setup_end    = (state_q == StSetup) && (cyc_q == CYC_W'(1));
    pulse_end    = (state_q == StPulseHi) && (cyc_q == CYC_W'(PULSE_CYC - 1));
    gap_end      = (state_q == StPulseLo) && (cyc_q == CYC_W'(GAP_CYC - 1));
    lock_timeout = (state_q == StWaitLock) && !pll_lock &&
                   (wait_q == WAIT_W'(LOCK_TO - 1));
    done_d       = (accept && !req_bad && (delta == '0)) ||
                   ((state_q == StWaitLock) && pll_lock);
    err_d        = (accept && req_bad) || lock_timeout;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (req_go) state_d = StSetup;
      StSetup:    if (setup_end) state_d = StPulseHi;
      StPulseHi:  if (pulse_end) state_d = StPulseLo;
      StPulseLo:  if (gap_end) state_d = (steps_q == '0) ? StWaitLock : StPulseHi;
      StWaitLock: if (pll_lock || lock_timeout) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state and the latched request.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    pspulse   = (state_q == StPulseHi);
    pssel     = ch_q;
    psdir     = dir_q;
    done      = done_q;
    err       = err_q;
  end

  // Datapath: latched request, cycle counters, strobes and per-channel phase.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ch_q    <= '0;
      dir_q   <= 1'b0;
      steps_q <= '0;
      cyc_q   <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) cur_q[i] <= '0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (state_d != state_q)    cyc_q <= '0;
      else if (state_q != StIdle) cyc_q <= cyc_q + CYC_W'(1);
      wait_q <= (state_q == StWaitLock) ? wait_q + WAIT_W'(1) : '0;
      if (req_go) begin
        ch_q    <= req_ch;
        dir_q   <= req_dir;
        steps_q <= req_steps;
      end
      // The phase moves as pspulse falls.
      if (pulse_end) begin
        steps_q <= steps_q - (STEP_W + 1)'(1);
        for (int unsigned i = 0; i < NCH; i++) begin
          if (ch_q == 3'(i)) cur_q[i] <= cur_next;
        end
      end
    end
  end

  // Flatten the per-channel phases, channel 0 in the LSBs.
  always_comb begin
    cur_phase = '0;
    for (int unsigned i = 0; i < NCH; i++) cur_phase[i*STEP_W +: STEP_W] = cur_q[i];
  end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Scoreboard bench for pll_phase_stepper. The driver predicts each
// operation's outcome from a per-channel phase model and queues it. The
// monitor watches the PLL control pins and pops one prediction per done/err
// strobe.
module tb_pll_phase_stepper;

  localparam int NCH       = 4;
  localparam int STEP_W    = 7;
  localparam int PERIOD    = 64;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 4;
  localparam int LOCK_TO   = 40;  // short so lock-timeout cases stay cheap

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_ch;
  logic [STEP_W-1:0]     req_phase;
  logic                  pll_lock;
  logic [2:0]            pssel;
  logic                  psdir;
  logic                  pspulse;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [NCH*STEP_W-1:0] cur_phase;

  pll_phase_stepper #(
    .NCH      (NCH),
    .STEP_W   (STEP_W),
    .PERIOD   (PERIOD),
    .PULSE_CYC(PULSE_CYC),
    .GAP_CYC  (GAP_CYC),
    .LOCK_TO  (LOCK_TO)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_ch   (req_ch),
    .req_phase(req_phase),
    .pll_lock (pll_lock),
    .pssel    (pssel),
    .psdir    (psdir),
    .pspulse  (pspulse),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cur_phase(cur_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                    is_err;
    int                    pulses;
    bit                    dir;
    int                    sel;
    int                    tail;
    logic [NCH*STEP_W-1:0] cur;
  } exp_t;

  exp_t sb[$];
  int   mc [NCH];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pulse shape, setup length, tail length and per-operation results.
  initial begin : monitor
    int  m_pulses, m_hi, m_lo, m_setup;
    bit  m_prev;
    int  m_sel;
    bit  m_dir;
    exp_t e;
    m_pulses = 0; m_hi = 0; m_lo = 0; m_setup = 0; m_prev = 0; m_sel = 0; m_dir = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_pulses = 0; m_hi = 0; m_lo = 0; m_setup = 0; m_prev = 0;
      end else begin
        if (pspulse) begin
          if (!m_prev) begin
            m_pulses++;
            if (m_pulses == 1) begin
              check("setup_len", m_setup, 2);
              m_sel = pssel;
              m_dir = psdir;
            end else begin
              check("gap_len", m_lo, GAP_CYC);
              check("pssel_stable", pssel, m_sel);
              check("psdir_stable", psdir, m_dir);
            end
            m_lo = 0;
          end
          m_hi++;
        end else begin
          if (m_prev) begin
            check("pulse_len", m_hi, PULSE_CYC);
            m_hi = 0;
          end
          if (busy) begin
            if (m_pulses == 0) m_setup++;
            else m_lo++;
          end
        end
        m_prev = pspulse;
        if (done || err) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: done=%0b err=%0b with no pending request", done, err);
          end else begin
            e = sb.pop_front();
            check("err_strobe", err, e.is_err);
            check("done_strobe", done, !e.is_err);
            check("busy_at_strobe", busy, 0);
            check("pulse_count", m_pulses, e.pulses);
            if (e.pulses > 0) begin
              check("psdir", m_dir, e.dir);
              check("pssel", m_sel, e.sel);
              check("tail_len", m_lo, e.tail);
            end
            check("cur_phase", cur_phase, e.cur);
          end
          m_pulses = 0; m_hi = 0; m_lo = 0; m_setup = 0;
        end
      end
    end
  end

  // Predict the outcome, present the request for one cycle, then disturb the
  // inputs while the operation is under way.
  task automatic issue(input int ch, input int ph, input bit lk);
    exp_t e;
    int   n, d;
    bit   inval;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_issue", req_ready, 1);
    inval    = (ch >= NCH) || (ph >= PERIOD);
    e.pulses = 0;
    e.dir    = 0;
    e.sel    = ch;
    e.tail   = 0;
    e.is_err = inval;
    if (!inval) begin
      d = ((ph - mc[ch]) % PERIOD + PERIOD) % PERIOD;
      if (d != 0) begin
        if (d <= PERIOD / 2) begin
          e.dir = 0; e.pulses = d;
        end else begin
          e.dir = 1; e.pulses = PERIOD - d;
        end
        mc[ch]   = ph;
        e.is_err = !lk;
        e.tail   = GAP_CYC + (lk ? 1 : LOCK_TO);
      end
    end
    for (int i = 0; i < NCH; i++) e.cur[i*STEP_W +: STEP_W] = mc[i][STEP_W-1:0];
    sb.push_back(e);
    pll_lock  = lk;
    req_valid = 1'b1;
    req_ch    = ch[2:0];
    req_phase = ph[STEP_W-1:0];
    @(negedge clk);
    req_ch    = 3'($urandom);
    req_phase = STEP_W'($urandom);
    if (e.pulses > 0) begin
      // Stray request and a lock glitch while stepping; both must be ignored.
      if (lk) pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = lk;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: no done/err within %0d cycles", budget);
    end
  endtask

  task automatic run(input int ch, input int ph, input bit lk);
    issue(ch, ph, lk);
    wait_end(LOCK_TO + 400);
    pll_lock = 1'b1;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int n, rises, ch, ph, r;
    bit prev, lk;
    for (int i = 0; i < NCH; i++) mc[i] = 0;
    resetn    = 1'b0;
    req_valid = 1'b0;
    req_ch    = '0;
    req_phase = '0;
    pll_lock  = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pspulse", pspulse, 0);
    check("rst_psdir", psdir, 0);
    check("rst_pssel", pssel, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_cur_phase", cur_phase, 0);

    run(2, 6, 1);     // six increments
    run(2, 60, 1);    // ten decrements through the 0 -> 63 wrap
    run(5, 3, 1);     // channel out of range
    run(1, 64, 1);    // phase out of range
    run(2, 60, 1);    // already there: done with no pulses
    run(2, 28, 1);    // exactly half a period: increments, wraps 63 -> 0
    run(0, 3, 0);     // lock never returns: timeout
    run(1, 63, 1);    // single decrement 0 -> 63

    // Reset in the middle of the third pulse.
    issue(3, 20, 1);
    n = 0; rises = 0; prev = pspulse;
    while (rises < 3 && n < 500) begin
      @(negedge clk);
      if (pspulse && !prev) rises++;
      prev = pspulse;
      n++;
    end
    check("third_pulse_seen", rises, 3);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_pspulse", pspulse, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pssel_psdir", {pssel, psdir}, 0);
    check("midrst_done_err", {done, err}, 0);
    check("midrst_cur_phase", cur_phase, 0);
    resetn = 1'b1;
    sb.delete();
    for (int i = 0; i < NCH; i++) mc[i] = 0;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1);

    for (int k = 0; k < 40; k++) begin
      ch = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NCH, 7))
                                       : int'($urandom_range(0, NCH - 1));
      r = $urandom_range(0, 9);
      if (r == 0)                 ph = $urandom_range(PERIOD, 127);
      else if (r == 1 && ch < NCH) ph = mc[ch];
      else                        ph = $urandom_range(0, PERIOD - 1);
      lk = ($urandom_range(0, 7) != 0);
      run(ch, ph, lk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
